// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
//   Round-robin scan sequencer placed directly upstream of a 2-to-4 one-hot
//   decoder. Visits the enabled channels of chan_mask in ascending order,
//   holds each one for DWELL_CYCLES with sel_en high, and precedes every
//   dwell with BLANK_CYCLES of sel_en low. With blanking, sel only changes on
//   an edge after which sel_en is low, so the decoder never glitches.
//
// Handshake: start is level-sampled in IDLE only (ignored while busy); stop
//   is sampled at every edge and beats start. No valid/ready pairs here.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       begin scanning (IDLE only, needs a non-zero chan_mask)
//   stop        abort scanning, returns to IDLE next cycle
//   chan_mask   bit i set = channel i takes part in the scan
//   sel         channel index to the decoder input (registered)
//   sel_en      decoder enable (registered)
//   busy        high whenever the sequencer is not IDLE (registered)
//   frame_done  one-cycle pulse when the scan wraps to the lowest channel
module decoder_scan_ctrl #(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned BLANK_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] chan_mask,
  output logic [1:0] sel,
  output logic       sel_en,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DWELL = 2'd2
  } state_t;

  localparam bit              NO_BLANK   = (BLANK_CYCLES == 0);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  // Unused when NO_BLANK; clamped so the subtraction cannot underflow.
  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'((BLANK_CYCLES == 0) ? 0 : (BLANK_CYCLES - 1));

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [1:0] first_idx;
  logic [1:0] next_idx;
  logic       next_found;
  logic [1:0] cand;
  logic       wrap;

  // Lowest set bit of the mask: scanned downwards so the last hit wins.
  always_comb begin
    first_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (chan_mask[i]) first_idx = 2'(i);
    end
  end

  // First set bit strictly above sel, wrapping 3->0. The 2-bit add wraps on
  // its own; the fourth candidate is sel itself (single-channel case).
  always_comb begin
    next_idx   = sel;
    next_found = 1'b0;
    cand       = sel;
    for (int i = 1; i <= 4; i++) begin
      cand = sel + 2'(i);
      if (!next_found && chan_mask[cand]) begin
        next_idx   = cand;
        next_found = 1'b1;
      end
    end
  end

  assign wrap = (next_idx <= sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= 2'd0;
      sel_en     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop && (chan_mask != 4'd0)) begin
            sel  <= first_idx;
            busy <= 1'b1;
            cnt  <= '0;
            if (NO_BLANK) begin
              state  <= DWELL;
              sel_en <= 1'b1;
            end else begin
              state  <= BLANK;
              sel_en <= 1'b0;
            end
          end
        end

        BLANK: begin
          if (stop) begin
            state  <= IDLE;
            sel_en <= 1'b0;
            busy   <= 1'b0;
            cnt    <= '0;
          end else if (cnt == BLANK_LAST) begin
            state  <= DWELL;
            sel_en <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DWELL: begin
          if (stop) begin
            state  <= IDLE;
            sel_en <= 1'b0;
            busy   <= 1'b0;
            cnt    <= '0;
          end else if (cnt == DWELL_LAST) begin
            cnt <= '0;
            // The mask is only consulted here, at the end of a dwell.
            if (chan_mask == 4'd0) begin
              state  <= IDLE;
              sel_en <= 1'b0;
              busy   <= 1'b0;
            end else begin
              sel        <= next_idx;
              frame_done <= wrap;
              if (NO_BLANK) begin
                state  <= DWELL;
                sel_en <= 1'b1;
              end else begin
                state  <= BLANK;
                sel_en <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state  <= IDLE;
          sel_en <= 1'b0;
          busy   <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl. Three builds share one set of inputs:
//   0: DWELL=4 BLANK=1, 1: DWELL=4 BLANK=0, 2: DWELL=3 BLANK=2.
// The reference model tracks, per build, only busy, the current channel,
// the position inside the channel slot (0 .. BLANK+DWELL-1) and the wrap
// pulse; sel_en is "position has passed the blanking part".
module tb_decoder_scan_ctrl;

  localparam int NB = 3;
  localparam int DW0 = 4, BL0 = 1;
  localparam int DW1 = 4, BL1 = 0;
  localparam int DW2 = 3, BL2 = 2;

  int dw_tab[NB] = '{DW0, DW1, DW2};
  int bl_tab[NB] = '{BL0, BL1, BL2};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] chan_mask = 4'd0;

  logic [1:0] sel_o      [NB];
  logic       sel_en_o   [NB];
  logic       busy_o     [NB];
  logic       frame_done_o[NB];

  decoder_scan_ctrl #(.DWELL_CYCLES(DW0), .BLANK_CYCLES(BL0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .chan_mask(chan_mask),
    .sel(sel_o[0]), .sel_en(sel_en_o[0]), .busy(busy_o[0]), .frame_done(frame_done_o[0]));
  decoder_scan_ctrl #(.DWELL_CYCLES(DW1), .BLANK_CYCLES(BL1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .chan_mask(chan_mask),
    .sel(sel_o[1]), .sel_en(sel_en_o[1]), .busy(busy_o[1]), .frame_done(frame_done_o[1]));
  decoder_scan_ctrl #(.DWELL_CYCLES(DW2), .BLANK_CYCLES(BL2), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .chan_mask(chan_mask),
    .sel(sel_o[2]), .sel_en(sel_en_o[2]), .busy(busy_o[2]), .frame_done(frame_done_o[2]));

  // ---------------- reference model ----------------
  bit m_busy[NB];
  int m_sel [NB];
  int m_pos [NB];
  bit m_fd  [NB];

  function automatic int lowest_ch(logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int next_ch(int cur, logic [3:0] m);
    for (int i = 1; i <= 4; i++) if (m[(cur + i) % 4]) return (cur + i) % 4;
    return cur;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NB; k++) begin
      m_busy[k] = 0; m_sel[k] = 0; m_pos[k] = 0; m_fd[k] = 0;
    end
  endtask

  task automatic model_edge(int k);
    int slot;
    slot = bl_tab[k] + dw_tab[k];
    m_fd[k] = 0;
    if (!m_busy[k]) begin
      if (start && !stop && chan_mask != 4'd0) begin
        m_busy[k] = 1; m_sel[k] = lowest_ch(chan_mask); m_pos[k] = 0;
      end
    end else if (stop) begin
      m_busy[k] = 0; m_pos[k] = 0;
    end else if (m_pos[k] == slot - 1) begin
      m_pos[k] = 0;
      if (chan_mask == 4'd0) m_busy[k] = 0;
      else begin
        int n;
        n = next_ch(m_sel[k], chan_mask);
        m_fd[k] = (n <= m_sel[k]);
        m_sel[k] = n;
      end
    end else begin
      m_pos[k] = m_pos[k] + 1;
    end
  endtask

  function automatic logic [5*NB-1:0] pack_exp();
    logic [5*NB-1:0] v;
    v = '0;
    for (int k = 0; k < NB; k++) begin
      v[k*5+3 +: 2] = 2'(m_sel[k]);
      v[k*5+2]      = m_busy[k] && (m_pos[k] >= bl_tab[k]);
      v[k*5+1]      = m_busy[k];
      v[k*5]        = m_fd[k];
    end
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [5*NB-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [5*NB-1:0] e;
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    for (int k = 0; k < NB; k++) begin
      check_eq($sformatf("sel[%0d]", k),        32'(sel_o[k]),        32'(e[k*5+3 +: 2]));
      check_eq($sformatf("sel_en[%0d]", k),     32'(sel_en_o[k]),     32'(e[k*5+2]));
      check_eq($sformatf("busy[%0d]", k),       32'(busy_o[k]),       32'(e[k*5+1]));
      check_eq($sformatf("frame_done[%0d]", k), 32'(frame_done_o[k]), 32'(e[k*5]));
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model follows the edge, outputs are compared at the negedge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int k = 0; k < NB; k++) model_edge(k);
    exp_q.push_back(pack_exp());
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start(logic [3:0] m);
    chan_mask = m; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // Reset asserted between edges must clear outputs without a clock.
  task automatic async_reset_check();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < NB; k++) begin
      check_eq($sformatf("arst_sel[%0d]", k),    32'(sel_o[k]),        0);
      check_eq($sformatf("arst_en[%0d]", k),     32'(sel_en_o[k]),     0);
      check_eq($sformatf("arst_busy[%0d]", k),   32'(busy_o[k]),       0);
      check_eq($sformatf("arst_fd[%0d]", k),     32'(frame_done_o[k]), 0);
    end
    @(negedge clk);
    run(2);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    @(negedge clk);
    run(3);
    rst_n = 1'b1;
    run(2);

    // full mask
    pulse_start(4'b1111);
    run(26);
    // start while busy is ignored
    pulse_start(4'b1111);
    run(6);
    pulse_stop();
    run(2);

    // stop during second dwell cycle of channel 1 (build 0 timing)
    pulse_start(4'b1111);
    run(7);
    pulse_stop();
    run(2);
    pulse_start(4'b1110);
    run(6);
    pulse_stop();

    // sparse and single-channel masks
    pulse_start(4'b1010);
    run(30);
    pulse_stop();
    pulse_start(4'b0100);
    run(20);

    // mask cleared mid-dwell: finish the dwell then go idle
    chan_mask = 4'b0000;
    run(12);

    // start with empty mask, and start together with stop
    pulse_start(4'b0000);
    run(3);
    stop = 1'b1;
    pulse_start(4'b0011);
    stop = 1'b0;
    run(3);

    // two-channel scan, then asynchronous reset mid-dwell
    pulse_start(4'b0011);
    run(20);
    async_reset_check();
    run(2);
    pulse_start(4'b1001);
    run(15);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 9) == 0) chan_mask = 4'($urandom_range(0, 15));
      step();
      if ($urandom_range(0, 700) == 0) begin
        start = 1'b0; stop = 1'b0;
        async_reset_check();
      end
    end
    start = 1'b0; stop = 1'b0;
    run(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
